// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: shared widths and FSM state encoding for the BCD convert scheduler
package bcd_sched_pkg;
  localparam int BIN_W = 8;
  localparam int DIGIT_W = 4;
  localparam int HUND_W = 2;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; req[1:0] in, one-hot grant[1:0] and grant_id out, last_grant updated on advance
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);
  logic last_grant_q, last_grant_d;
  always_comb begin
    grant_id = (&req) ? ~last_grant_q : req[1];
    grant = (|req) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    last_grant_d = advance ? grant_id : last_grant_q;
  end
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: shares one external binary-to-BCD converter between two valid/ready requesters; req_* in, conv_bin/conv_* to the converter, resp_* valid/ready out, busy status
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid_0,
  input  logic [BIN_W-1:0]   req_data_0,
  output logic               req_ready_0,
  input  logic               req_valid_1,
  input  logic [BIN_W-1:0]   req_data_1,
  output logic               req_ready_1,
  output logic [BIN_W-1:0]   conv_bin,
  input  logic [DIGIT_W-1:0] conv_ones,
  input  logic [DIGIT_W-1:0] conv_tens,
  input  logic [HUND_W-1:0]  conv_hundreds,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [DIGIT_W-1:0] resp_ones,
  output logic [DIGIT_W-1:0] resp_tens,
  output logic [HUND_W-1:0]  resp_hundreds,
  output logic               resp_err,
  output logic               busy
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] conv_bin_q, conv_bin_d;
  logic resp_valid_q, resp_valid_d;
  logic resp_id_q, resp_id_d;
  logic [DIGIT_W-1:0] resp_ones_q, resp_ones_d, resp_tens_q, resp_tens_d;
  logic [HUND_W-1:0] resp_hundreds_q, resp_hundreds_d;
  logic resp_err_q, resp_err_d;
  logic idle;
  logic [1:0] req, grant;
  logic grant_id;
  assign idle = state_q == IDLE;
  // Requests are only visible to the arbiter in IDLE, so grants and readies cannot occur elsewhere.
  assign req = {req_valid_1, req_valid_0} & {2{idle}};
  rr_arbiter_2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .advance  (|req),
    .grant    (grant),
    .grant_id (grant_id)
  );
  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    conv_bin_d = conv_bin_q;
    resp_valid_d = resp_valid_q;
    resp_id_d = resp_id_q;
    resp_ones_d = resp_ones_q;
    resp_tens_d = resp_tens_q;
    resp_hundreds_d = resp_hundreds_q;
    resp_err_d = resp_err_q;
    case (state_q)
      IDLE: if (|grant) begin
        conv_bin_d = grant_id ? req_data_1 : req_data_0;
        resp_id_d = grant_id;
        cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: if (cnt_q == '0) begin
        resp_ones_d = conv_ones;
        resp_tens_d = conv_tens;
        resp_hundreds_d = conv_hundreds;
        resp_err_d = (conv_ones > 4'd9) || (conv_tens > 4'd9);
        resp_valid_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q - CNT_W'(1);
      RESP: if (resp_valid_q && resp_ready) begin
        resp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      conv_bin_q <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= 1'b0;
      resp_ones_q <= '0;
      resp_tens_q <= '0;
      resp_hundreds_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      conv_bin_q <= conv_bin_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      resp_ones_q <= resp_ones_d;
      resp_tens_q <= resp_tens_d;
      resp_hundreds_q <= resp_hundreds_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign conv_bin = conv_bin_q;
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_ones = resp_ones_q;
  assign resp_tens = resp_tens_q;
  assign resp_hundreds = resp_hundreds_q;
  assign resp_err = resp_err_q;
  assign busy = !idle;
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: directed self-checking bench for bcd_convert_scheduler
module tb_bcd_convert_scheduler;
  logic clk = 0;
  logic reset = 1;
  logic rv0 = 0, rv1 = 0, rr0, rr1, resp_valid, resp_ready = 0, resp_id, r_err, busy;
  logic [7:0] rd0 = 0, rd1 = 0, conv_bin;
  logic [3:0] c_ones, c_tens, r_ones, r_tens;
  logic [1:0] c_hund, r_hund;
  logic stub = 0;
  logic [3:0] stub_ones = 0, stub_tens = 0;
  logic rst4 = 1, v40 = 0, v41 = 0, r40, r41, cb_dummy, rv4, rr4 = 0, id4, e4, busy4;
  logic [7:0] d40 = 0, d41 = 0, cb4;
  logic [3:0] o4, t4, co4, ct4;
  logic [1:0] h4, ch4;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  always_comb begin
    c_ones = stub ? stub_ones : 4'(conv_bin % 8'd10);
    c_tens = stub ? stub_tens : 4'((conv_bin / 8'd10) % 8'd10);
    c_hund = stub ? 2'd0 : 2'(conv_bin / 8'd100);
  end
  assign co4 = 4'(cb4 % 8'd10);
  assign ct4 = 4'((cb4 / 8'd10) % 8'd10);
  assign ch4 = 2'(cb4 / 8'd100);
  assign cb_dummy = 1'b0;
  bcd_convert_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid_0(rv0), .req_data_0(rd0), .req_ready_0(rr0),
    .req_valid_1(rv1), .req_data_1(rd1), .req_ready_1(rr1),
    .conv_bin(conv_bin), .conv_ones(c_ones), .conv_tens(c_tens), .conv_hundreds(c_hund),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ones(r_ones), .resp_tens(r_tens), .resp_hundreds(r_hund), .resp_err(r_err),
    .busy(busy)
  );
  bcd_convert_scheduler #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(rst4),
    .req_valid_0(v40), .req_data_0(d40), .req_ready_0(r40),
    .req_valid_1(v41), .req_data_1(d41), .req_ready_1(r41),
    .conv_bin(cb4), .conv_ones(co4), .conv_tens(ct4), .conv_hundreds(ch4),
    .resp_valid(rv4), .resp_ready(rr4), .resp_id(id4),
    .resp_ones(o4), .resp_tens(t4), .resp_hundreds(h4), .resp_err(e4),
    .busy(busy4)
  );
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
  endtask
  task automatic transact(input bit id, input logic [7:0] d, input logic [3:0] eo, input logic [3:0] et,
                          input logic [1:0] eh, input logic ee, input string nm);
    int w, lat;
    if (id) begin rv1 = 1; rd1 = d; end else begin rv0 = 1; rd0 = d; end
    #1;
    w = 0;
    while (!(id ? rr1 : rr0) && w < 20) begin @(negedge clk); #1; w++; end
    compared++;
    if (w >= 20) begin mismatched++; $display("FAIL %s grant: ready never seen within %0d cycles", nm, w); end
    @(negedge clk);
    rv0 = id ? rv0 : 1'b0;
    rv1 = id ? 1'b0 : rv1;
    #1;
    compared++;
    if ((id ? rr1 : rr0) !== 1'b0) begin mismatched++; $display("FAIL %s ready_pulse: ready still %b after accept, want 0", nm, id ? rr1 : rr0); end
    compared++;
    if (conv_bin !== d) begin mismatched++; $display("FAIL %s conv_bin: got %0d want %0d", nm, conv_bin, d); end
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); #1; lat++; end
    compared++;
    if (lat !== 3) begin mismatched++; $display("FAIL %s latency: got %0d edges want 3", nm, lat); end
    compared++;
    if ({resp_id, r_hund, r_tens, r_ones, r_err} !== {id, eh, et, eo, ee})
      begin mismatched++; $display("FAIL %s resp: got id=%b h=%0d t=%0h o=%0h err=%b want id=%b h=%0d t=%0h o=%0h err=%b",
                                    nm, resp_id, r_hund, r_tens, r_ones, r_err, id, eh, et, eo, ee); end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    #1;
    compared++;
    if ({resp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL %s handshake: got valid=%b busy=%b want 0 0", nm, resp_valid, busy); end
  endtask
  task automatic test_reset();
    do_reset();
    compared++;
    if ({busy, resp_valid, resp_id, r_err, rr0, rr1} !== 6'b0) begin mismatched++; $display("FAIL reset_flags: got %b want 000000", {busy, resp_valid, resp_id, r_err, rr0, rr1}); end
    compared++;
    if ({conv_bin, r_hund, r_tens, r_ones} !== 18'b0) begin mismatched++; $display("FAIL reset_data: got bin=%0d h=%0d t=%0d o=%0d want all 0", conv_bin, r_hund, r_tens, r_ones); end
  endtask
  task automatic test_single();
    transact(0, 8'd255, 4'd5, 4'd5, 2'd2, 1'b0, "single_255");
  endtask
  task automatic test_req1();
    transact(1, 8'd0, 4'd0, 4'd0, 2'd0, 1'b0, "req1_0");
    transact(1, 8'd109, 4'd9, 4'd0, 2'd1, 1'b0, "req1_109");
  endtask
  task automatic test_back_to_back();
    int k, both, cyc;
    logic [8:0] got [4];
    do_reset();
    rv0 = 1; rd0 = 8'd10; rv1 = 1; rd1 = 8'd20; resp_ready = 1;
    k = 0; both = 0; cyc = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk); #1; cyc++;
      if (rr0 && rr1) both++;
      if (resp_valid) begin got[k] = {resp_id, r_tens, r_ones}; k++; end
    end
    rv0 = 0; rv1 = 0;
    @(negedge clk);
    resp_ready = 0;
    compared++;
    if (k !== 4) begin mismatched++; $display("FAIL b2b_count: got %0d responses want 4", k); end
    compared++;
    if (both !== 0) begin mismatched++; $display("FAIL b2b_one_ready: got %0d cycles with both ready want 0", both); end
    for (int i = 0; i < k; i++) begin
      compared++;
      if (got[i] !== (i[0] ? {1'b1, 4'd2, 4'd0} : {1'b0, 4'd1, 4'd0}))
        begin mismatched++; $display("FAIL b2b_resp%0d: got id=%b t=%0d o=%0d want id=%0d t=%0d o=0", i, got[i][8], got[i][7:4], got[i][3:0], i[0], i[0] ? 2 : 1); end
    end
  endtask
  task automatic test_stall();
    int w, bad;
    rv0 = 1; rd0 = 8'd123; resp_ready = 0;
    #1;
    w = 0;
    while (!rr0 && w < 20) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    rv0 = 0; rv1 = 1; rd1 = 8'd45;
    w = 0;
    #1;
    while (resp_valid !== 1'b1 && w < 20) begin @(negedge clk); #1; w++; end
    compared++;
    if ({resp_valid, resp_id, r_hund, r_tens, r_ones, r_err} !== {1'b1, 1'b0, 2'd1, 4'd2, 4'd3, 1'b0})
      begin mismatched++; $display("FAIL stall_resp: got v=%b id=%b h=%0d t=%0d o=%0d err=%b want 1 0 1 2 3 0", resp_valid, resp_id, r_hund, r_tens, r_ones, r_err); end
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if ({resp_valid, r_hund, r_tens, r_ones, rr0, rr1} !== {1'b1, 2'd1, 4'd2, 4'd3, 1'b0, 1'b0}) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    resp_ready = 1;
    #1;
    compared++;
    if (rr1 !== 1'b0) begin mismatched++; $display("FAIL stall_handshake_ready: got %b want 0", rr1); end
    @(negedge clk);
    resp_ready = 0;
    #1;
    compared++;
    if ({resp_valid, rr1} !== 2'b01) begin mismatched++; $display("FAIL stall_release: got valid=%b ready1=%b want 0 1", resp_valid, rr1); end
    transact(1, 8'd45, 4'd5, 4'd4, 2'd0, 1'b0, "stall_next");
  endtask
  task automatic test_err();
    stub = 1; stub_ones = 4'hA; stub_tens = 4'h3;
    transact(0, 8'd7, 4'hA, 4'h3, 2'd0, 1'b1, "err_ones_a");
    stub_ones = 4'h3; stub_tens = 4'h9;
    transact(1, 8'd93, 4'h3, 4'h9, 2'd0, 1'b0, "err_tens_9");
    stub = 0;
  endtask
  task automatic test_reset_settle();
    int seen, lat;
    @(negedge clk);
    rst4 = 1;
    repeat (2) @(negedge clk);
    rst4 = 0; v40 = 1; d40 = 8'd77;
    #1;
    compared++;
    if (r40 !== 1'b1) begin mismatched++; $display("FAIL rs_grant: got ready0=%b want 1", r40); end
    @(negedge clk);
    v40 = 0;
    #1;
    compared++;
    if ({busy4, cb4} !== {1'b1, 8'd77}) begin mismatched++; $display("FAIL rs_settle: got busy=%b bin=%0d want 1 77", busy4, cb4); end
    @(negedge clk);
    rst4 = 1;
    @(negedge clk);
    rst4 = 0;
    #1;
    compared++;
    if ({busy4, rv4, cb4} !== 10'b0) begin mismatched++; $display("FAIL rs_after_reset: got busy=%b valid=%b bin=%0d want 0 0 0", busy4, rv4, cb4); end
    rr4 = 1; seen = 0;
    repeat (10) begin @(negedge clk); #1; if (rv4) seen++; end
    compared++;
    if (seen !== 0) begin mismatched++; $display("FAIL rs_dropped: got %0d response cycles want 0", seen); end
    v40 = 1; d40 = 8'd30; v41 = 1; d41 = 8'd40;
    #1;
    compared++;
    if ({r40, r41} !== 2'b10) begin mismatched++; $display("FAIL rs_tie: got ready0=%b ready1=%b want 1 0", r40, r41); end
    @(negedge clk);
    v40 = 0; v41 = 0;
    #1;
    lat = 1;
    while (rv4 !== 1'b1 && lat < 20) begin @(negedge clk); #1; lat++; end
    compared++;
    if (lat !== 5) begin mismatched++; $display("FAIL rs_latency: got %0d edges want 5", lat); end
    compared++;
    if ({id4, h4, t4, o4, e4} !== {1'b0, 2'd0, 4'd3, 4'd0, 1'b0})
      begin mismatched++; $display("FAIL rs_resp: got id=%b h=%0d t=%0d o=%0d err=%b want 0 0 3 0 0", id4, h4, t4, o4, e4); end
    @(negedge clk);
    #1;
    compared++;
    if (rv4 !== 1'b0) begin mismatched++; $display("FAIL rs_handshake: got valid=%b want 0", rv4); end
    rr4 = 0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_req1();
    test_back_to_back();
    test_stall();
    test_err();
    test_reset_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
